// File: rtl/demux1_8_tdm.sv
// Receive side of the 8-slot TDM link: realigns beats to frame_sync and
// presents each completed 8-slot frame in parallel. Define
// DEMUX1_8_TDM_SYNC_CHECK_EN to require frame_sync on every slot-0 beat.
module demux1_8_tdm #(
  parameter int DATA_W = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     din,
  input  logic                  din_valid,
  input  logic                  frame_sync,
  output logic [8*DATA_W-1:0]   frame_data,
  output logic                  frame_valid,
  output logic [2:0]            slot,
  output logic                  locked,
  output logic                  sync_err
);

  localparam int FRAME_W = 8 * DATA_W;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Handshake: a beat is any rising edge with din_valid=1; there is no
  // backpressure, din and frame_sync are ignored whenever din_valid=0.

  state_t               state_q, state_n;
  logic [2:0]           slot_q, slot_n;
  logic [FRAME_W-1:0]   buf_q, buf_n;
  logic [FRAME_W-1:0]   frame_q, frame_n;
  logic                 fvalid_q, fvalid_n;
  logic                 serr_q, serr_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      slot_q   <= 3'd0;
      buf_q    <= '0;
      frame_q  <= '0;
      fvalid_q <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      slot_q   <= slot_n;
      buf_q    <= buf_n;
      frame_q  <= frame_n;
      fvalid_q <= fvalid_n;
      serr_q   <= serr_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    slot_n   = slot_q;
    buf_n    = buf_q;
    frame_n  = frame_q;
    fvalid_n = 1'b0;
    serr_n   = 1'b0;

    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (frame_sync) begin
            buf_n               = '0;
            buf_n[DATA_W-1:0]   = din;
            slot_n              = 3'd1;
            state_n             = LOCKED;
          end
        end

        LOCKED: begin
          if (frame_sync && (slot_q != 3'd0)) begin
            // Misplaced sync wins over completion: drop the partial frame
            // and restart with this beat as slot 0.
            serr_n              = 1'b1;
            buf_n               = '0;
            buf_n[DATA_W-1:0]   = din;
            slot_n              = 3'd1;
`ifdef DEMUX1_8_TDM_SYNC_CHECK_EN
          end else if (!frame_sync && (slot_q == 3'd0)) begin
            serr_n              = 1'b1;
            buf_n               = '0;
            slot_n              = 3'd0;
            state_n             = HUNT;
`endif
          end else begin
            buf_n[int'(slot_q)*DATA_W +: DATA_W] = din;
            slot_n = slot_q + 3'd1;
            if (slot_q == 3'd7) begin
              frame_n  = {din, buf_q[7*DATA_W-1:0]};
              fvalid_n = 1'b1;
            end
          end
        end

        default: begin
          state_n = HUNT;
          slot_n  = 3'd0;
        end
      endcase
    end
  end

  assign frame_data  = frame_q;
  assign frame_valid = fvalid_q;
  assign slot        = slot_q;
  assign locked      = (state_q == LOCKED);
  assign sync_err    = serr_q;

endmodule

// File: tb/tb_demux1_8_tdm.sv
// Directed bench for demux1_8_tdm (DATA_W=1): lock, gaps, hunt discard,
// resync, mid-frame reset and the slot-0 missing-sync case.
module tb_demux1_8_tdm;

  logic       clk;
  logic       rst;
  logic [0:0] din;
  logic       din_valid;
  logic       frame_sync;
  logic [7:0] frame_data;
  logic       frame_valid;
  logic [2:0] slot;
  logic       locked;
  logic       sync_err;

  int n_cmp;
  int n_err;

  demux1_8_tdm #(.DATA_W(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .slot        (slot),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic beat(input logic d, input logic fs);
    @(negedge clk);
    din        = d;
    din_valid  = 1'b1;
    frame_sync = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    din_valid  = 1'b0;
    frame_sync = 1'b1;
    din        = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_frame_data", frame_data, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_slot", slot, 0);
    chk("rst_locked", locked, 0);
    chk("rst_sync_err", sync_err, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0] pat;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    din = '0;
    din_valid = 1'b0;
    frame_sync = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // Frame 8'hAA, back-to-back
    pat = 8'hAA;
    beat(pat[0], 1'b1);
    chk("aa_locked_after_sync", locked, 1);
    chk("aa_slot_after_sync", slot, 1);
    for (int k = 1; k < 7; k++) beat(pat[k], 1'b0);
    chk("aa_no_early_valid", frame_valid, 0);
    beat(pat[7], 1'b0);
    chk("aa_frame_valid", frame_valid, 1);
    chk("aa_frame_data", frame_data, 8'hAA);
    chk("aa_slot_wrap", slot, 0);
    chk("aa_locked", locked, 1);
    idle();
    chk("aa_valid_one_cycle", frame_valid, 0);
    chk("aa_data_held", frame_data, 8'hAA);

    // Frame 8'hFF with a 5-cycle gap after slot 3
    for (int k = 0; k < 4; k++) beat(1'b1, k == 0);
    for (int g = 0; g < 5; g++) begin
      idle();
      chk("gap_slot_held", slot, 4);
      chk("gap_no_valid", frame_valid, 0);
    end
    for (int k = 4; k < 8; k++) beat(1'b1, 1'b0);
    chk("ff_frame_valid", frame_valid, 1);
    chk("ff_frame_data", frame_data, 8'hFF);
    idle();
    chk("ff_valid_one_cycle", frame_valid, 0);

    // Unsynced beats in HUNT are discarded
    do_reset();
    for (int k = 0; k < 3; k++) beat(1'b1, 1'b0);
    chk("hunt_slot", slot, 0);
    chk("hunt_locked", locked, 0);
    pat = 8'h0F;
    for (int k = 0; k < 8; k++) beat(pat[k], k == 0);
    chk("0f_frame_valid", frame_valid, 1);
    chk("0f_frame_data", frame_data, 8'h0F);

    // Misplaced sync at slot 5
    for (int k = 0; k < 5; k++) beat(1'b1, k == 0);
    pat = 8'h5A;
    beat(pat[0], 1'b1);
    chk("resync5_sync_err", sync_err, 1);
    chk("resync5_no_valid", frame_valid, 0);
    chk("resync5_slot", slot, 1);
    chk("resync5_locked", locked, 1);
    for (int k = 1; k < 8; k++) begin
      beat(pat[k], 1'b0);
      if (k == 1) chk("resync5_err_one_cycle", sync_err, 0);
    end
    chk("5a_frame_valid", frame_valid, 1);
    chk("5a_frame_data", frame_data, 8'h5A);

    // Misplaced sync on slot 7: error wins over completion
    for (int k = 0; k < 7; k++) beat(1'b0, k == 0);
    pat = 8'hC3;
    beat(pat[0], 1'b1);
    chk("resync7_sync_err", sync_err, 1);
    chk("resync7_no_valid", frame_valid, 0);
    chk("resync7_data_held", frame_data, 8'h5A);
    for (int k = 1; k < 8; k++) beat(pat[k], 1'b0);
    chk("c3_frame_valid", frame_valid, 1);
    chk("c3_frame_data", frame_data, 8'hC3);

    // Reset at slot 4 of a frame
    for (int k = 0; k < 4; k++) beat(1'b1, k == 0);
    chk("pre_rst_slot", slot, 4);
    do_reset();
    pat = 8'h3C;
    for (int k = 0; k < 8; k++) beat(pat[k], k == 0);
    chk("3c_frame_valid", frame_valid, 1);
    chk("3c_frame_data", frame_data, 8'h3C);

    // Slot-0 beat without frame_sync
    pat = 8'h96;
    beat(pat[0], 1'b0);
`ifdef DEMUX1_8_TDM_SYNC_CHECK_EN
    chk("miss_sync_err", sync_err, 1);
    chk("miss_locked", locked, 0);
    chk("miss_slot", slot, 0);
    for (int k = 1; k < 8; k++) beat(pat[k], 1'b0);
    chk("miss_no_valid", frame_valid, 0);
    chk("miss_data_held", frame_data, 8'h3C);
    chk("miss_still_hunting", locked, 0);
`else
    chk("nosync_no_err", sync_err, 0);
    chk("nosync_locked", locked, 1);
    chk("nosync_slot", slot, 1);
    for (int k = 1; k < 8; k++) beat(pat[k], 1'b0);
    chk("96_frame_valid", frame_valid, 1);
    chk("96_frame_data", frame_data, 8'h96);
`endif
    idle();
    chk("final_no_valid", frame_valid, 0);
    chk("final_no_err", sync_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
